// File: rtl/ime_bist_seq.sv
// IME built-in self-test sequencer: streams a CSR-loaded vector table into the IME
// stream input and grades each frame's accumulator result against exp_acc +/- tol.
module ime_bist_seq #(
  parameter int W_P     = 16,
  parameter int W_LOG   = 16,
  parameter int W_ACC   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               bist_cmd,
  input  logic [1:0]               mode,
  input  logic [7:0]               loop_cnt,
  input  logic                     stop_on_fail,
  input  logic [15:0]              frame_len,
  input  logic [7:0]               tol,
  input  logic [W_ACC-1:0]         exp_acc,
  input  logic                     vec_wr_en,
  input  logic [$clog2(DEPTH)-1:0] vec_wr_addr,
  input  logic [2*W_P+W_LOG-1:0]   vec_wr_data,
  output logic                     bist_active,
  output logic [2*W_P+W_LOG-1:0]   bist_tdata,
  output logic [7:0]               bist_tuser,
  output logic                     bist_tvalid,
  input  logic                     bist_tready,
  output logic                     bist_tlast,
  input  logic [W_ACC-1:0]         obs_acc,
  input  logic [7:0]               obs_tuser,
  input  logic                     obs_valid,
  input  logic                     obs_last,
  output logic [1:0]               bist_status,
  output logic                     timeout_flag,
  output logic                     wr_err,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              fail_cnt,
  output logic                     poison_inject
);
  localparam int AW  = $clog2(DEPTH);
  localparam int VW  = 2*W_P+W_LOG;
  localparam int WDW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state_reg;
  logic [AW-1:0]    index_reg;
  logic [AW-1:0]    last_reg;
  logic [7:0]       frame_reg;
  logic [WDW-1:0]   wd_reg;
  logic [15:0]      pass_reg;
  logic [15:0]      fail_reg;
  logic             tflag_reg;
  logic             werr_reg;
  logic [1:0]       mode_reg;
  logic [7:0]       loop_reg;
  logic             stop_reg;
  logic [W_ACC-1:0] exp_reg;
  logic [7:0]       tol_reg;

  logic [VW-1:0]    vec_mem [DEPTH];

  logic             start_ok;
  logic [AW-1:0]    len_last;
  logic             obs_hit;
  logic             wd_fire;
  logic             frame_eval;
  logic             frame_ok;
  logic             more_frames;
  logic [W_ACC-1:0] diff;

  assign bist_active = (state_reg == S_STREAM) || (state_reg == S_WAIT);
  assign bist_tvalid = (state_reg == S_STREAM);
  assign bist_tlast  = bist_tvalid && (index_reg == last_reg);
  assign bist_tdata  = vec_mem[index_reg];
  assign bist_tuser  = {frame_reg[2:0], 5'(index_reg)};

  // Asynchronous table read so a write on the start cycle is visible on the first beat.
  always_ff @(posedge clk) begin
    if (vec_wr_en && !bist_active) begin
      vec_mem[vec_wr_addr] <= vec_wr_data;
    end
  end

  assign start_ok = (bist_cmd == 2'b01) && !bist_active;

  always_comb begin
    len_last = AW'(DEPTH - 1);
    if (frame_len != 16'd0 && frame_len <= 16'(DEPTH)) begin
      len_last = AW'(frame_len - 16'd1);
    end
  end

  // Absolute difference taken in the larger-minus-smaller order so it never wraps.
  assign diff       = (obs_acc >= exp_reg) ? (obs_acc - exp_reg) : (exp_reg - obs_acc);
  assign obs_hit    = (state_reg == S_WAIT) && obs_valid && obs_last;
  assign wd_fire    = (state_reg == S_WAIT) && !obs_hit && (wd_reg == WDW'(TIMEOUT - 1));
  assign frame_eval = obs_hit || wd_fire;
  assign frame_ok   = obs_hit
                    && (diff <= {{(W_ACC-8){1'b0}}, tol_reg})
                    && (obs_tuser[7:5] == frame_reg[2:0])
                    && (obs_tuser[4:0] == 5'(last_reg));

  always_comb begin
    more_frames = 1'b0;
    case (mode_reg)
      2'b10:   more_frames = 1'b1;
      2'b01:   more_frames = ({1'b0, frame_reg} + 9'd1) < {1'b0, loop_reg};
      default: more_frames = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      index_reg <= '0;
      last_reg  <= '0;
      frame_reg <= '0;
      wd_reg    <= '0;
      pass_reg  <= '0;
      fail_reg  <= '0;
      tflag_reg <= 1'b0;
      werr_reg  <= 1'b0;
      mode_reg  <= '0;
      loop_reg  <= 8'd1;
      stop_reg  <= 1'b0;
      exp_reg   <= '0;
      tol_reg   <= '0;
    end else begin
      if (vec_wr_en && bist_active) begin
        werr_reg <= 1'b1;
      end
      if (bist_cmd == 2'b10) begin
        state_reg <= S_IDLE;
        index_reg <= '0;
      end else if (start_ok) begin
        state_reg <= S_STREAM;
        mode_reg  <= mode;
        loop_reg  <= (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
        stop_reg  <= stop_on_fail;
        exp_reg   <= exp_acc;
        tol_reg   <= tol;
        last_reg  <= len_last;
        index_reg <= '0;
        frame_reg <= '0;
        pass_reg  <= '0;
        fail_reg  <= '0;
        tflag_reg <= 1'b0;
        werr_reg  <= 1'b0;
      end else begin
        case (state_reg)
          S_STREAM: begin
            if (bist_tready) begin
              if (index_reg == last_reg) begin
                index_reg <= '0;
                wd_reg    <= '0;
                state_reg <= S_WAIT;
              end else begin
                index_reg <= index_reg + AW'(1);
              end
            end
          end
          S_WAIT: begin
            if (frame_eval) begin
              if (frame_ok) begin
                if (pass_reg != 16'hFFFF) pass_reg <= pass_reg + 16'd1;
              end else begin
                if (fail_reg != 16'hFFFF) fail_reg <= fail_reg + 16'd1;
              end
              if (wd_fire) tflag_reg <= 1'b1;
              frame_reg <= frame_reg + 8'd1;
              if ((!frame_ok && stop_reg) || !more_frames) begin
                state_reg <= S_DONE;
              end else begin
                state_reg <= S_STREAM;
              end
            end else begin
              wd_reg <= wd_reg + WDW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bist_status = 2'b00;
    case (state_reg)
      S_STREAM, S_WAIT: bist_status = 2'b01;
      S_DONE:           bist_status = (fail_reg == 16'd0) ? 2'b10 : 2'b11;
      default:          bist_status = 2'b00;
    endcase
  end

  assign poison_inject = (bist_status == 2'b11);
  assign timeout_flag  = tflag_reg;
  assign wr_err        = werr_reg;
  assign pass_cnt      = pass_reg;
  assign fail_cnt      = fail_reg;

endmodule

// File: tb/tb_ime_bist_seq.sv
// Bench for ime_bist_seq: directed single-frame table, hand-written multi-cycle
// sequences and randomized campaigns graded by a frame-level reference model.
module tb_ime_bist_seq;
  localparam int W_P     = 16;
  localparam int W_LOG   = 16;
  localparam int W_ACC   = 32;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 16;
  localparam int VW      = 2*W_P+W_LOG;
  localparam int AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       bist_cmd = '0;
  logic [1:0]       mode = '0;
  logic [7:0]       loop_cnt = '0;
  logic             stop_on_fail = 1'b0;
  logic [15:0]      frame_len = '0;
  logic [7:0]       tol = '0;
  logic [W_ACC-1:0] exp_acc = '0;
  logic             vec_wr_en = 1'b0;
  logic [AW-1:0]    vec_wr_addr = '0;
  logic [VW-1:0]    vec_wr_data = '0;
  logic             bist_active;
  logic [VW-1:0]    bist_tdata;
  logic [7:0]       bist_tuser;
  logic             bist_tvalid;
  logic             bist_tready = 1'b0;
  logic             bist_tlast;
  logic [W_ACC-1:0] obs_acc = '0;
  logic [7:0]       obs_tuser = '0;
  logic             obs_valid = 1'b0;
  logic             obs_last = 1'b0;
  logic [1:0]       bist_status;
  logic             timeout_flag;
  logic             wr_err;
  logic [15:0]      pass_cnt;
  logic [15:0]      fail_cnt;
  logic             poison_inject;

  int n_cmp = 0;
  int n_err = 0;
  logic [VW-1:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] expv;
    logic [7:0]  tolv;
    logic [31:0] acc;
    int          bad;   // 0 good tuser, 1 wrong frame field, 2 wrong index field
    logic [1:0]  st;
  } vec_t;
  vec_t vt [10];

  ime_bist_seq #(.W_P(W_P), .W_LOG(W_LOG), .W_ACC(W_ACC), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bist_cmd(bist_cmd), .mode(mode), .loop_cnt(loop_cnt),
    .stop_on_fail(stop_on_fail), .frame_len(frame_len), .tol(tol), .exp_acc(exp_acc),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
    .bist_active(bist_active), .bist_tdata(bist_tdata), .bist_tuser(bist_tuser),
    .bist_tvalid(bist_tvalid), .bist_tready(bist_tready), .bist_tlast(bist_tlast),
    .obs_acc(obs_acc), .obs_tuser(obs_tuser), .obs_valid(obs_valid), .obs_last(obs_last),
    .bist_status(bist_status), .timeout_flag(timeout_flag), .wr_err(wr_err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .poison_inject(poison_inject)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s act=%0h req=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input int addr, input logic [VW-1:0] data);
    vec_wr_en   = 1'b1;
    vec_wr_addr = AW'(addr);
    vec_wr_data = data;
    tick();
    vec_wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic start(input int m, input int lc, input int sp, input int fl,
                       input logic [7:0] t, input logic [31:0] e);
    mode = 2'(m); loop_cnt = 8'(lc); stop_on_fail = sp[0]; frame_len = 16'(fl);
    tol = t; exp_acc = e; bist_cmd = 2'b01;
    tick();
    bist_cmd = 2'b00;
    check("start_tvalid", bist_tvalid, 1);
    check("start_status", bist_status, 2'b01);
  endtask

  // Streams one frame, checking every presented beat against the table model.
  task automatic stream(input int beats_req, input int fidx, input int rmode);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (bist_tvalid === 1'b1 && cyc < 400) begin
      check("tdata", bist_tdata, model_mem[idx % DEPTH]);
      check("tuser", bist_tuser, {fidx[2:0], 5'(idx)});
      check("tlast", bist_tlast, idx == beats_req - 1);
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      bist_tready = rdy;
      if (rmode == 2) begin
        obs_valid = 1'($urandom_range(0, 1));
        obs_last  = obs_valid;
        obs_acc   = $urandom;
      end
      tick();
      cyc++;
      if (rdy) idx++;
    end
    bist_tready = 1'b0;
    obs_valid = 1'b0;
    obs_last = 1'b0;
    check("beats", idx, beats_req);
    check("wait_active", bist_active, 1);
  endtask

  task automatic respond(input int delay, input logic [31:0] acc, input logic [7:0] tu);
    repeat (delay) tick();
    obs_valid = 1'b1; obs_last = 1'b1; obs_acc = acc; obs_tuser = tu;
    tick();
    obs_valid = 1'b0; obs_last = 1'b0;
  endtask

  function automatic int flen_eff(input int f);
    return (f == 0 || f > DEPTH) ? DEPTH : f;
  endfunction

  function automatic bit model_pass(input longint acc, input longint e, input longint t,
                                    input logic [7:0] tu, input int fidx, input int last);
    longint d;
    d = acc - e;
    if (d < 0) d = -d;
    return (d <= t) && (tu[7:5] == fidx[2:0]) && (tu[4:0] == last[4:0]);
  endfunction

  initial begin
    logic [63:0] r;
    logic [7:0]  tu;
    vt[0] = '{32'd4096,       8'd8,   32'd4100,       0, 2'b10};
    vt[1] = '{32'd4096,       8'd4,   32'd4092,       0, 2'b10};
    vt[2] = '{32'd4096,       8'd4,   32'd4091,       0, 2'b11};
    vt[3] = '{32'd4096,       8'd4,   32'd4100,       0, 2'b10};
    vt[4] = '{32'd4096,       8'd4,   32'd4101,       0, 2'b11};
    vt[5] = '{32'hFFFF_FFFF,  8'd255, 32'd0,          0, 2'b11};
    vt[6] = '{32'd0,          8'd255, 32'hFFFF_FFFF,  0, 2'b11};
    vt[7] = '{32'd100,        8'd0,   32'd100,        0, 2'b10};
    vt[8] = '{32'd4096,       8'd8,   32'd4096,       1, 2'b11};
    vt[9] = '{32'd4096,       8'd8,   32'd4096,       2, 2'b11};

    repeat (3) tick();
    check("rst_status", bist_status, 2'b00);
    check("rst_tvalid", bist_tvalid, 0);
    check("rst_active", bist_active, 0);
    check("rst_flags", {timeout_flag, wr_err, poison_inject, bist_tlast}, 4'b0000);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("idle_status", bist_status, 2'b00);

    for (int a = 0; a < DEPTH; a++) begin
      r = {$urandom, $urandom};
      write_vec(a, r[VW-1:0]);
    end

    // Single-frame table: tolerance edges, no-wrap difference, tuser field checks.
    for (int i = 0; i < 10; i++) begin
      tu = (vt[i].bad == 1) ? 8'h23 : (vt[i].bad == 2) ? 8'h02 : 8'h03;
      start(0, 0, 0, 4, vt[i].tolv, vt[i].expv);
      stream(4, 0, 0);
      respond(0, vt[i].acc, tu);
      check($sformatf("tbl%0d_status", i), bist_status, vt[i].st);
      check($sformatf("tbl%0d_pass", i), pass_cnt, (vt[i].st == 2'b10) ? 1 : 0);
      check($sformatf("tbl%0d_fail", i), fail_cnt, (vt[i].st == 2'b11) ? 1 : 0);
      check($sformatf("tbl%0d_poison", i), poison_inject, vt[i].st == 2'b11);
      $display("table vector %0d exp=%0d tol=%0d acc=%0d status=%b", i, vt[i].expv, vt[i].tolv, vt[i].acc, bist_status);
    end

    // Counted loop of 3, second frame reports the wrong frame field.
    start(1, 3, 0, 4, 8'd8, 32'd4096);
    stream(4, 0, 0); respond(0, 32'd4100, 8'h03);
    check("loop_next0", bist_tvalid, 1);
    stream(4, 1, 0); respond(2, 32'd4100, 8'h03);
    check("loop_next1", bist_tvalid, 1);
    stream(4, 2, 0); respond(1, 32'd4096, 8'h43);
    check("loop_pass", pass_cnt, 2);
    check("loop_fail", fail_cnt, 1);
    check("loop_status", bist_status, 2'b11);
    $display("loop campaign pass=%0d fail=%0d status=%b", pass_cnt, fail_cnt, bist_status);

    // Stop-on-fail ends a counted loop at the first failing frame.
    start(1, 3, 1, 4, 8'd8, 32'd4096);
    stream(4, 0, 0); respond(0, 32'd5000, 8'h03);
    check("sof_tvalid", bist_tvalid, 0);
    check("sof_status", bist_status, 2'b11);
    check("sof_counts", {pass_cnt, fail_cnt}, {16'd0, 16'd1});
    $display("stop_on_fail campaign status=%b", bist_status);

    // Clamp frame_len 0 to DEPTH under toggling backpressure.
    start(0, 0, 0, 0, 8'd8, 32'd4096);
    stream(DEPTH, 0, 1); respond(0, 32'd4096, 8'h0F);
    check("clamp_status", bist_status, 2'b10);
    $display("clamp campaign status=%b", bist_status);

    // Watchdog with no response.
    start(0, 0, 0, 4, 8'd8, 32'd4096);
    stream(4, 0, 0);
    repeat (TIMEOUT - 1) tick();
    check("wd_early_flag", timeout_flag, 0);
    check("wd_early_status", bist_status, 2'b01);
    tick();
    check("wd_flag", timeout_flag, 1);
    check("wd_fail", fail_cnt, 1);
    check("wd_status", bist_status, 2'b11);
    $display("watchdog campaign flag=%b fail=%0d", timeout_flag, fail_cnt);

    // Response on the expiry cycle wins over the watchdog.
    start(0, 0, 0, 4, 8'd8, 32'd4096);
    stream(4, 0, 0);
    respond(TIMEOUT - 1, 32'd4096, 8'h03);
    check("wdobs_status", bist_status, 2'b10);
    check("wdobs_flag", timeout_flag, 0);
    $display("watchdog-vs-obs campaign status=%b", bist_status);

    // Abort mid-STREAM after a rejected table write.
    start(0, 0, 0, 8, 8'd8, 32'd4096);
    bist_tready = 1'b1;
    tick(); tick();
    vec_wr_en = 1'b1; vec_wr_addr = AW'(5); vec_wr_data = ~model_mem[5];
    tick();
    vec_wr_en = 1'b0;
    check("wr_err_set", wr_err, 1);
    bist_cmd = 2'b10;
    tick();
    bist_cmd = 2'b00; bist_tready = 1'b0;
    check("abort_status", bist_status, 2'b00);
    check("abort_tvalid", bist_tvalid, 0);
    check("abort_wr_err", wr_err, 1);
    start(0, 0, 0, 8, 8'd8, 32'd4096);
    check("wr_err_clear", wr_err, 0);
    stream(8, 0, 0); respond(0, 32'd4090, 8'h07);
    check("after_abort_status", bist_status, 2'b10);
    $display("abort/write-protect campaign status=%b", bist_status);

    // Write on the start cycle is visible on the first beat.
    vec_wr_en = 1'b1; vec_wr_addr = '0; vec_wr_data = 48'hA5A5_1234_5678;
    start(0, 0, 0, 2, 8'd0, 32'd7);
    vec_wr_en = 1'b0;
    model_mem[0] = 48'hA5A5_1234_5678;
    check("start_write_tdata", bist_tdata, 48'hA5A5_1234_5678);
    stream(2, 0, 0); respond(0, 32'd7, 8'h01);
    check("start_write_status", bist_status, 2'b10);
    $display("write-with-start campaign status=%b", bist_status);

    // Continuous mode, then abort; counters hold.
    start(2, 0, 0, 2, 8'd0, 32'd9);
    stream(2, 0, 0); respond(0, 32'd9, 8'h01);
    check("cont_next0", bist_tvalid, 1);
    stream(2, 1, 0); respond(0, 32'd9, 8'h21);
    check("cont_next1", bist_tvalid, 1);
    bist_cmd = 2'b10;
    tick();
    bist_cmd = 2'b00;
    check("cont_abort_status", bist_status, 2'b00);
    check("cont_abort_pass", pass_cnt, 2);
    $display("continuous campaign aborted pass=%0d", pass_cnt);

    // Randomized campaigns against the frame-level model.
    for (int c = 0; c < 14; c++) begin
      int m, lc, sp, fl, nfr, last, pcnt, fcnt, dl;
      bit fp, nr, tf;
      logic [31:0] ex, acc;
      logic [7:0]  tl, tux;
      for (int a = 0; a < DEPTH; a++) begin
        r = {$urandom, $urandom};
        write_vec(a, r[VW-1:0]);
      end
      m = $urandom_range(0, 3);
      if (m == 2) m = 1;
      lc = $urandom_range(0, 4);
      sp = $urandom_range(0, 1);
      fl = $urandom_range(0, 20);
      ex = (c % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      tl = 8'($urandom_range(0, 255));
      nfr = (m == 1) ? ((lc == 0) ? 1 : lc) : 1;
      last = flen_eff(fl) - 1;
      pcnt = 0; fcnt = 0; tf = 0;
      start(m, lc, sp, fl, tl, ex);
      for (int f = 0; f < nfr; f++) begin
        stream(flen_eff(fl), f, 2);
        dl  = int'($urandom_range(0, 2*int'(tl) + 6)) - (int'(tl) + 3);
        acc = ex + 32'(dl);
        tux = {3'(f), 5'(last)};
        if ($urandom_range(0, 5) == 0) tux = tux ^ (8'h01 << $urandom_range(0, 7));
        nr = ($urandom_range(0, 9) == 0);
        if (nr) begin
          repeat (TIMEOUT) tick();
          fp = 0;
          tf = 1;
        end else begin
          respond($urandom_range(0, TIMEOUT - 1), acc, tux);
          fp = model_pass(longint'(acc), longint'(ex), longint'(tl), tux, f, last);
        end
        if (fp) pcnt++; else fcnt++;
        check("rnd_pass", pass_cnt, pcnt);
        check("rnd_fail", fail_cnt, fcnt);
        if (f == nfr - 1 || (!fp && sp != 0)) begin
          check("rnd_done_tvalid", bist_tvalid, 0);
          check("rnd_status", bist_status, (fcnt == 0) ? 2'b10 : 2'b11);
          check("rnd_poison", poison_inject, fcnt != 0);
          check("rnd_tflag", timeout_flag, tf);
          break;
        end else begin
          check("rnd_next_tvalid", bist_tvalid, 1);
        end
      end
      $display("random campaign %0d mode=%0d loop=%0d stop=%0d len=%0d pass=%0d fail=%0d status=%b",
               c, m, lc, sp, fl, pass_cnt, fail_cnt, bist_status);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
